// File: rtl/mul_unit.sv
// Multi-cycle WIDTH-bit MUL/MLA unit, two multiplier bits per cycle with early exit.
// Returns the low WIDTH bits of rm*rs (+rn) and optional N/Z flags.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             accumulate,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] rm,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_we,
  output logic             n_flag,
  output logic             z_flag
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] acc_sum;
  logic [CW-1:0]    count;
  logic             s_latched;
  logic             last;

  // Radix-4 partial product: 0, 1x, 2x or 3x the multiplicand.
  always_comb begin
    partial = '0;
    case (mplier[1:0])
      2'd0:    partial = '0;
      2'd1:    partial = mcand;
      2'd2:    partial = mcand << 1;
      default: partial = mcand + (mcand << 1);
    endcase
    acc_sum = acc + partial;
    last    = (mplier[WIDTH-1:2] == '0) || (count == LAST_CNT);
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    flag_we   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        flag_we   = s_latched;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      s_latched <= 1'b0;
      result    <= '0;
      n_flag    <= 1'b0;
      z_flag    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand     <= rm;
            mplier    <= rs;
            acc       <= accumulate ? rn : '0;
            s_latched <= set_flags;
            count     <= '0;
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 2;
          mplier <= mplier >> 2;
          count  <= count + CW'(1);
          if (last) begin
            result <= acc_sum;
            if (s_latched) begin
              n_flag <= acc_sum[WIDTH-1];
              z_flag <= (acc_sum == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
